// File: rtl/spi3w_pkg.sv
// Header layout, byte-count codes and FSM states shared by the
// 3-wire SPI config responder.
package spi3w_pkg;
    localparam int HDR_BITS = 16;
    localparam int RW_BIT   = 15;
    localparam int W_MSB    = 14;
    localparam int W_LSB    = 13;

    typedef enum logic [1:0] {
        W_ONE    = 2'b00,
        W_TWO    = 2'b01,
        W_THREE  = 2'b10,
        W_STREAM = 2'b11
    } bcnt_e;

    typedef enum logic [2:0] {IDLE, INSTR, WDATA, RDATA, DONE} state_e;
endpackage

// File: rtl/spi3w_sync_edge.sv
// Two-flop synchroniser with a delayed copy for single-cycle rise/fall pulses.
module spi3w_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_20m,
    input  logic rstn,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);
    // [0],[1] form the synchroniser, [2] is the previous synchronised value
    logic [2:0] pipe_q;

    always_ff @(posedge clk_20m) begin
        if (!rstn) pipe_q <= {3{RST_VAL}};
        else       pipe_q <= {pipe_q[1:0], d_i};
    end

    assign sync_o = pipe_q[1];
    assign rise_o = pipe_q[1] & ~pipe_q[2];
    assign fall_o = ~pipe_q[1] & pipe_q[2];
endmodule

// File: rtl/spi3w_cfg_slave.sv
// AD9517/AD9434-style 3-wire SPI responder with an 8-bit register file;
// SCLK is oversampled in clk_20m and never used as a clock.
module spi3w_cfg_slave
    import spi3w_pkg::*;
#(
    parameter int                    REG_DEPTH  = 256,
    parameter int                    ADDR_WIDTH = 13,
    parameter logic [7:0]            RESET_VAL  = 8'h00,
    parameter logic [ADDR_WIDTH-1:0] RO_ADDR    = '0,
    parameter logic [7:0]            ID_VAL     = 8'hA5
) (
    input  logic                  clk_20m,
    input  logic                  rstn,
    input  logic                  spi_sclk,
    input  logic                  spi_cs_n,
    input  logic                  spi_sdio_i,
    output logic                  spi_sdio_o,
    output logic                  spi_sdio_t,
    input  logic [ADDR_WIDTH-1:0] loc_rd_addr,
    output logic [7:0]            loc_rd_data,
    output logic                  o_wr_stb,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [7:0]            o_wr_data,
    output logic                  o_busy,
    output logic                  o_frame_err
);
    localparam int                IDX_W   = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(REG_DEPTH);

    logic sclk_s, sclk_rise, sclk_fall;
    logic [1:0] cs_q, sdio_q;
    logic cs_s, sdio_s;

    spi3w_sync_edge #(.RST_VAL(1'b0)) u_sclk (
        .clk_20m (clk_20m),
        .rstn    (rstn),
        .d_i     (spi_sclk),
        .sync_o  (sclk_s),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    // CS resets deasserted so a reset never looks like a frame start
    always_ff @(posedge clk_20m) begin
        if (!rstn) begin
            cs_q   <= 2'b11;
            sdio_q <= 2'b00;
        end else begin
            cs_q   <= {cs_q[0], spi_cs_n};
            sdio_q <= {sdio_q[0], spi_sdio_i};
        end
    end
    assign cs_s   = cs_q[1];
    assign sdio_s = sdio_q[1];

    logic [7:0] mem_q [REG_DEPTH];

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} < DEPTH_W;
    endfunction

    function automatic logic [7:0] rd_byte(input logic [ADDR_WIDTH-1:0] a);
        if (a == RO_ADDR) return ID_VAL;
        if (in_range(a))  return mem_q[a[IDX_W-1:0]];
        return 8'h00;
    endfunction

    state_e                state_q, state_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [HDR_BITS-2:0]   sreg_q, sreg_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            rem_q, rem_d;
    logic                  stream_q, stream_d;
    logic                  load_q, load_d;
    logic [6:0]            tx_q, tx_d;
    logic                  sdio_o_q, sdio_o_d, sdio_t_q, sdio_t_d;
    logic                  wr_stb_q, wr_stb_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]            wr_data_q, wr_data_d;
    logic                  frame_err_q, frame_err_d;
    logic                  busy_q, busy_d;

    logic [HDR_BITS-1:0] hdr;
    logic [7:0]          byte_in, rd_val;
    logic                wr_ok, mem_we, byte_done, sclk_unused;

    assign hdr         = {sreg_q, sdio_s};
    assign byte_in     = {sreg_q[6:0], sdio_s};
    assign rd_val      = rd_byte(addr_q);
    assign wr_ok       = in_range(addr_q) && (addr_q != RO_ADDR);
    assign sclk_unused = sclk_s;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        sreg_d      = sreg_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        stream_d    = stream_q;
        load_d      = load_q;
        tx_d        = tx_q;
        sdio_o_d    = sdio_o_q;
        sdio_t_d    = sdio_t_q;
        wr_stb_d    = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = 1'b0;
        busy_d      = ~cs_s;
        mem_we      = 1'b0;
        byte_done   = 1'b0;

        if (sclk_rise) sreg_d = hdr[HDR_BITS-2:0];

        case (state_q)
            IDLE: begin
                sdio_t_d = 1'b1;
                sdio_o_d = 1'b0;
                if (!cs_s) begin
                    state_d   = INSTR;
                    bit_cnt_d = '0;
                end
            end
            INSTR: if (sclk_rise) begin
                if (bit_cnt_q == 4'd15) begin
                    state_d   = hdr[RW_BIT] ? RDATA : WDATA;
                    addr_d    = hdr[ADDR_WIDTH-1:0];
                    rem_d     = hdr[W_MSB:W_LSB];
                    stream_d  = (hdr[W_MSB:W_LSB] == W_STREAM);
                    load_d    = 1'b1;
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            WDATA: if (sclk_rise) begin
                if (bit_cnt_q == 4'd7) begin
                    byte_done = 1'b1;
                    if (wr_ok) begin
                        mem_we    = 1'b1;
                        wr_stb_d  = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = byte_in;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            RDATA: begin
                // first fall of each byte fetches it; later falls shift it out
                if (sclk_fall) begin
                    sdio_t_d = 1'b0;
                    if (load_q) begin
                        sdio_o_d = rd_val[7];
                        tx_d     = rd_val[6:0];
                        load_d   = 1'b0;
                    end else begin
                        sdio_o_d = tx_q[6];
                        tx_d     = {tx_q[5:0], 1'b0};
                    end
                end
                if (sclk_rise) begin
                    if (bit_cnt_q == 4'd7) begin
                        byte_done = 1'b1;
                        load_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            DONE: begin
                sdio_t_d = 1'b1;
                sdio_o_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        if (byte_done) begin
            bit_cnt_d = '0;
            addr_d    = addr_q - ADDR_WIDTH'(1);
            if (!stream_q && rem_q == 2'd0) begin
                state_d  = DONE;
                sdio_t_d = 1'b1;
                sdio_o_d = 1'b0;
            end else if (!stream_q) begin
                rem_d = rem_q - 2'd1;
            end
        end

        // a byte completing on the same cycle leaves bit_cnt_d at zero: no error
        if (cs_s && state_q != IDLE) begin
            state_d     = IDLE;
            sdio_t_d    = 1'b1;
            sdio_o_d    = 1'b0;
            frame_err_d = (state_q inside {INSTR, WDATA, RDATA}) && (bit_cnt_d != 4'd0);
        end
    end

    always_ff @(posedge clk_20m) begin
        if (!rstn) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            sreg_q      <= '0;
            addr_q      <= '0;
            rem_q       <= '0;
            stream_q    <= 1'b0;
            load_q      <= 1'b0;
            tx_q        <= '0;
            sdio_o_q    <= 1'b0;
            sdio_t_q    <= 1'b1;
            wr_stb_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            sreg_q      <= sreg_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            stream_q    <= stream_d;
            load_q      <= load_d;
            tx_q        <= tx_d;
            sdio_o_q    <= sdio_o_d;
            sdio_t_q    <= sdio_t_d;
            wr_stb_q    <= wr_stb_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    always_ff @(posedge clk_20m) begin
        if (!rstn) begin
            for (int i = 0; i < REG_DEPTH; i++) mem_q[i] <= RESET_VAL;
        end else if (mem_we) begin
            mem_q[addr_q[IDX_W-1:0]] <= byte_in;
        end
    end

    always_comb loc_rd_data = rd_byte(loc_rd_addr);

    assign spi_sdio_o  = sdio_o_q;
    assign spi_sdio_t  = sdio_t_q;
    assign o_wr_stb    = wr_stb_q;
    assign o_wr_addr   = wr_addr_q;
    assign o_wr_data   = wr_data_q;
    assign o_busy      = busy_q;
    assign o_frame_err = frame_err_q;
endmodule
